muldiv_iter: RTL and testbench

Iterative RV64M multiply/divide unit sitting beside the EX stage. EX drives operands, operand signedness and a request strobe; this block runs a radix-2 shift-add multiply or restoring divide over a fixed number of cycles, holds the pipeline via a stall request, and returns a 128-bit product or quotient/remainder pair on the result buses EX selects from.

---
 rtl/muldiv_iter.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_iter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV64M multiply/divide unit beside the EX stage.
// A radix-2 shift-add multiply or restoring divide runs one bit per cycle.
// The unit holds the pipeline through stall_o until the result is ready.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid_i     M-extension instruction present in EX, held while stalled
//   funct3_i        [2] 0=multiply 1=divide; [1:0] are decoded by EX, which
//                   selects between result_l_o and result_h_o
//   word_i          *W variant: operands truncated to 32 bits, results sign-extended
//   rs1_data_i      operand A / dividend
//   rs2_data_i      operand B / divisor
//   rs1_sign_i      treat A as signed
//   rs2_sign_i      treat B as signed
//   flush_i         kill the in-flight operation
//   stall_o         pipeline hold request (combinational)
//   busy_o          unit not idle
//   result_valid_o  one-cycle pulse when the results are valid
//   result_l_o      product[63:0] or quotient
//   result_h_o      product[127:64] or remainder
module muldiv_iter #(
    parameter int XLEN = 64,
    parameter int ITER = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    input  logic [2:0]      funct3_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            rs1_sign_i,
    input  logic            rs2_sign_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_l_o,
    output logic [XLEN-1:0] result_h_o
);
    localparam int HW = XLEN / 2;
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;

    logic [CW-1:0]   counter;
    logic [XLEN-1:0] acc_hi;   // multiply: upper product half; divide: partial remainder
    logic [XLEN-1:0] acc_lo;   // multiply: multiplier/low product; divide: dividend/quotient
    logic [XLEN-1:0] opb;      // multiplicand or divisor magnitude
    logic            is_div;
    logic            is_word;
    logic            neg_lo;   // negate product, or negate quotient
    logic            neg_hi;   // negate remainder

    // Quotient/remainder selection happens in EX; only bit 2 matters here.
    logic unused_funct3;
    assign unused_funct3 = ^funct3_i[1:0];

    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] x);
        return {{HW{x[HW-1]}}, x[HW-1:0]};
    endfunction

    // ---------------- accept-time operand preparation ----------------
    logic            accept;
    logic            div_in;
    logic            div_signed;
    logic            sa, sb;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] spec_q, spec_r;

    always_comb begin
        accept     = (state == IDLE) & req_valid_i & ~flush_i;
        div_in     = funct3_i[2];
        div_signed = rs1_sign_i & rs2_sign_i;
        if (word_i) begin
            a_ext = {{HW{rs1_sign_i & rs1_data_i[HW-1]}}, rs1_data_i[HW-1:0]};
            b_ext = {{HW{rs2_sign_i & rs2_data_i[HW-1]}}, rs2_data_i[HW-1:0]};
        end else begin
            a_ext = rs1_data_i;
            b_ext = rs2_data_i;
        end
        sa = (div_in ? div_signed : rs1_sign_i) & a_ext[XLEN-1];
        sb = (div_in ? div_signed : rs2_sign_i) & b_ext[XLEN-1];
        a_mag = sa ? -a_ext : a_ext;
        b_mag = sb ? -b_ext : b_ext;
        // Most-negative value; in word mode it is -2^31 sign-extended.
        min_neg  = word_i ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = div_in & (b_ext == '0);
        div_ovf  = div_in & div_signed & (a_ext == min_neg) & (b_ext == '1);
        special  = div_zero | div_ovf;
        spec_q   = div_zero ? '1 : a_ext;
        spec_r   = div_zero ? a_ext : '0;
    end

    // ---------------- one iteration of the datapath ----------------
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fin_l, fin_h;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, opb};
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        if (is_div) begin
            // Invariant rem < divisor keeps the subtracted remainder within XLEN bits.
            if (div_shift >= {1'b0, opb}) begin
                step_hi = div_shift[XLEN-1:0] - opb;
                step_lo = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_shift[XLEN-1:0];
                step_lo = {acc_lo[XLEN-2:0], 1'b0};
            end
        end else if (acc_lo[0]) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end else begin
            step_hi = {1'b0, acc_hi[XLEN-1:1]};
            step_lo = {acc_hi[0], acc_lo[XLEN-1:1]};
        end
        prod_fix = neg_lo ? -{step_hi, step_lo} : {step_hi, step_lo};
        if (is_div) begin
            fin_l = neg_lo ? -step_lo : step_lo;
            fin_h = neg_hi ? -step_hi : step_hi;
        end else begin
            fin_l = prod_fix[XLEN-1:0];
            fin_h = prod_fix[2*XLEN-1:XLEN];
        end
        if (is_word) begin
            fin_l = wext(fin_l);
            fin_h = wext(fin_h);
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        stall_o        = req_valid_i & ~flush_i & (state != DONE);
        busy_o         = (state != IDLE);
        result_valid_o = (state == DONE) & ~flush_i;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: begin
                if (flush_i)                         state_next = IDLE;
                else if (counter == CW'(ITER - 1))   state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter    <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opb        <= '0;
            is_div     <= 1'b0;
            is_word    <= 1'b0;
            neg_lo     <= 1'b0;
            neg_hi     <= 1'b0;
            result_l_o <= '0;
            result_h_o <= '0;
        end else if (accept) begin
            counter <= '0;
            acc_hi  <= '0;
            acc_lo  <= a_mag;
            opb     <= b_mag;
            is_div  <= div_in;
            is_word <= word_i;
            neg_lo  <= sa ^ sb;
            neg_hi  <= sa;
            if (special) begin
                result_l_o <= word_i ? wext(spec_q) : spec_q;
                result_h_o <= word_i ? wext(spec_r) : spec_r;
            end
        end else if (state == CALC && !flush_i) begin
            acc_hi  <= step_hi;
            acc_lo  <= step_lo;
            counter <= counter + CW'(1);
            if (counter == CW'(ITER - 1)) begin
                result_l_o <= fin_l;
                result_h_o <= fin_h;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  funct3 = '0;
    logic        word = 1'b0;
    logic [63:0] rs1 = '0, rs2 = '0;
    logic        rs1_sign = 1'b0, rs2_sign = 1'b0;
    logic        flush = 1'b0;
    logic        stall, busy, result_valid;
    logic [63:0] result_l, result_h;

    int n_cmp = 0;
    int n_fail = 0;

    muldiv_iter #(.XLEN(64), .ITER(64)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .funct3_i(funct3),
        .word_i(word), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .rs1_sign_i(rs1_sign), .rs2_sign_i(rs2_sign), .flush_i(flush),
        .stall_o(stall), .busy_o(busy), .result_valid_o(result_valid),
        .result_l_o(result_l), .result_h_o(result_h)
    );

    always #5 clk = ~clk;

    // Issue one request and follow it to completion (or a 200-cycle bound).
    // lat = cycles from accept to the result_valid pulse (-1 on timeout).
    task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic s1, input logic s2,
                         output int lat, output int stalls, output logic [63:0] lo,
                         output logic [63:0] hi, output logic extra);
        lat = -1; stalls = 0; lo = '0; hi = '0; extra = 1'b0;
        @(negedge clk);
        funct3 = f3; word = w; rs1 = a; rs2 = b; rs1_sign = s1; rs2_sign = s2;
        req_valid = 1'b1;
        #1;
        for (int i = 0; i < 200; i++) begin
            if (stall) stalls++;
            if (result_valid) begin
                lat = i; lo = result_l; hi = result_h;
                req_valid = 1'b0;
                @(negedge clk); #1;
                extra = result_valid;
                break;
            end
            @(negedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (result_l !== 64'd0) begin n_fail++; $display("FAIL reset_l got %h want 0", result_l); end
        n_cmp++; if (result_h !== 64'd0) begin n_fail++; $display("FAIL reset_h got %h want 0", result_h); end
        n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", result_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
        rst = 1'b0;
        $display("reset: l=%h h=%h busy=%b", result_l, result_h, busy);
    endtask

    task automatic test_mul();
        int lat, stalls; logic [63:0] lo, hi; logic extra;
        // MUL signed 7 * -3 = -21
        do_op(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1, lat, stalls, lo, hi, extra);
        $display("MUL 7*-3: lat=%0d stall=%0d l=%h h=%h", lat, stalls, lo, hi);
        n_cmp++; if (lo !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mul_l got %h want ffffffffffffffeb", lo); end
        n_cmp++; if (hi !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL mul_h got %h want ffffffffffffffff", hi); end
        n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL mul_latency got %0d want 65", lat); end
        n_cmp++; if (stalls !== 65) begin n_fail++; $display("FAIL mul_stall got %0d want 65", stalls); end
        n_cmp++; if (extra !== 1'b0) begin n_fail++; $display("FAIL mul_pulse_width got %b want 0 after DONE", extra); end
        // MULHU all-ones squared
        do_op(3'b011, 1'b0, '1, '1, 1'b0, 1'b0, lat, stalls, lo, hi, extra);
        $display("MULHU ff..*ff..: lat=%0d l=%h h=%h", lat, lo, hi);
        n_cmp++; if (hi !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL mulhu_h got %h want fffffffffffffffe", hi); end
        n_cmp++; if (lo !== 64'h1) begin n_fail++; $display("FAIL mulhu_l got %h want 1", lo); end
        n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL mulhu_latency got %0d want 65", lat); end
        // MULHSU -1 * 2 (rs2 unsigned)
        do_op(3'b010, 1'b0, '1, 64'd2, 1'b1, 1'b0, lat, stalls, lo, hi, extra);
        $display("MULHSU -1*2: lat=%0d l=%h h=%h", lat, lo, hi);
        n_cmp++; if (hi !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_h got %h want ffffffffffffffff", hi); end
        n_cmp++; if (lo !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL mulhsu_l got %h want fffffffffffffffe", lo); end
    endtask

    task automatic test_div();
        int lat, stalls; logic [63:0] lo, hi; logic extra;
        do_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, lat, stalls, lo, hi, extra);
        $display("DIV -7/2: lat=%0d stall=%0d q=%h r=%h", lat, stalls, lo, hi);
        n_cmp++; if (lo !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_q got %h want fffffffffffffffd", lo); end
        n_cmp++; if (hi !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL div_r got %h want ffffffffffffffff", hi); end
        n_cmp++; if (stalls !== 65) begin n_fail++; $display("FAIL div_stall got %0d want 65", stalls); end
        do_op(3'b101, 1'b0, 64'd100, 64'd7, 1'b0, 1'b0, lat, stalls, lo, hi, extra);
        $display("DIVU 100/7: lat=%0d stall=%0d q=%h r=%h", lat, stalls, lo, hi);
        n_cmp++; if (lo !== 64'd14) begin n_fail++; $display("FAIL divu_q got %h want e", lo); end
        n_cmp++; if (hi !== 64'd2) begin n_fail++; $display("FAIL divu_r got %h want 2", hi); end
        n_cmp++; if (stalls !== 65) begin n_fail++; $display("FAIL divu_stall got %0d want 65", stalls); end
        n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL divu_latency got %0d want 65", lat); end
    endtask

    task automatic test_div_special();
        int lat, stalls; logic [63:0] lo, hi; logic extra;
        do_op(3'b101, 1'b0, 64'd5, 64'd0, 1'b0, 1'b0, lat, stalls, lo, hi, extra);
        $display("DIVU 5/0: lat=%0d stall=%0d q=%h r=%h", lat, stalls, lo, hi);
        n_cmp++; if (lo !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL div0_q got %h want ffffffffffffffff", lo); end
        n_cmp++; if (hi !== 64'd5) begin n_fail++; $display("FAIL div0_r got %h want 5", hi); end
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL div0_latency got %0d want 1", lat); end
        n_cmp++; if (stalls !== 1) begin n_fail++; $display("FAIL div0_stall got %0d want 1", stalls); end
        do_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b1, 1'b1, lat, stalls, lo, hi, extra);
        $display("DIV min/-1: lat=%0d q=%h r=%h", lat, lo, hi);
        n_cmp++; if (lo !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL ovf_q got %h want 8000000000000000", lo); end
        n_cmp++; if (hi !== 64'd0) begin n_fail++; $display("FAIL ovf_r got %h want 0", hi); end
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ovf_latency got %0d want 1", lat); end
    endtask

    task automatic test_word();
        int lat, stalls; logic [63:0] lo, hi; logic extra;
        do_op(3'b100, 1'b1, 64'h1234_5678_8000_0000, '1, 1'b1, 1'b1, lat, stalls, lo, hi, extra);
        $display("DIVW min/-1: lat=%0d q=%h r=%h", lat, lo, hi);
        n_cmp++; if (lo !== 64'hFFFF_FFFF_8000_0000) begin n_fail++; $display("FAIL divw_ovf_q got %h want ffffffff80000000", lo); end
        n_cmp++; if (hi !== 64'd0) begin n_fail++; $display("FAIL divw_ovf_r got %h want 0", hi); end
        do_op(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 1'b1, 1'b1, lat, stalls, lo, hi, extra);
        $display("MULW 7fffffff*2: lat=%0d l=%h", lat, lo);
        n_cmp++; if (lo !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL mulw_l got %h want fffffffffffffffe", lo); end
        n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL mulw_latency got %0d want 65", lat); end
        do_op(3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, lat, stalls, lo, hi, extra);
        $display("DIVW -7/2: lat=%0d q=%h r=%h", lat, lo, hi);
        n_cmp++; if (lo !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL divw_q got %h want fffffffffffffffd", lo); end
        n_cmp++; if (hi !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL divw_r got %h want ffffffffffffffff", hi); end
        do_op(3'b101, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'd2, 1'b0, 1'b0, lat, stalls, lo, hi, extra);
        $display("DIVUW 7/2: lat=%0d q=%h r=%h", lat, lo, hi);
        n_cmp++; if (lo !== 64'd3) begin n_fail++; $display("FAIL divuw_q got %h want 3", lo); end
        n_cmp++; if (hi !== 64'd1) begin n_fail++; $display("FAIL divuw_r got %h want 1", hi); end
    endtask

    // Results from DIVUW 7/2 (q=3, r=1) must survive a flushed multiply.
    task automatic test_flush();
        logic seen;
        @(negedge clk);
        funct3 = 3'b000; word = 1'b0; rs1 = 64'd3; rs2 = 64'd5; rs1_sign = 1'b0; rs2_sign = 1'b0;
        req_valid = 1'b1;
        repeat (30) @(negedge clk);
        flush = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", stall); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got %b want 1", busy); end
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle got busy=%b want 0", busy); end
        seen = 1'b0;
        repeat (80) begin @(negedge clk); #1; if (result_valid) seen = 1'b1; end
        $display("flush at T+30: seen_valid=%b l=%h h=%h", seen, result_l, result_h);
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_valid got %b want 0", seen); end
        n_cmp++; if (result_l !== 64'd3) begin n_fail++; $display("FAIL flush_keep_l got %h want 3", result_l); end
        n_cmp++; if (result_h !== 64'd1) begin n_fail++; $display("FAIL flush_keep_h got %h want 1", result_h); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        funct3 = 3'b000; word = 1'b0; rs1 = 64'd9; rs2 = 64'd9; req_valid = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1; req_valid = 1'b0;
        #1;
        $display("async reset at T+10: l=%h h=%h busy=%b valid=%b", result_l, result_h, busy, result_valid);
        n_cmp++; if (result_l !== 64'd0) begin n_fail++; $display("FAIL areset_l got %h want 0", result_l); end
        n_cmp++; if (result_h !== 64'd0) begin n_fail++; $display("FAIL areset_h got %h want 0", result_h); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %b want 0", busy); end
        n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", result_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t1, t2; logic [63:0] l1, l2;
        t1 = -1; t2 = -1; l1 = '0; l2 = '0;
        @(negedge clk);
        funct3 = 3'b000; word = 1'b0; rs1 = 64'd2; rs2 = 64'd3; rs1_sign = 1'b1; rs2_sign = 1'b1;
        req_valid = 1'b1;
        #1;
        for (int i = 0; i < 300; i++) begin
            if (result_valid) begin
                if (t1 < 0) begin
                    t1 = i; l1 = result_l;
                    rs1 = 64'd4; rs2 = 64'd5;   // next request presented in the DONE cycle
                end else begin
                    t2 = i; l2 = result_l;
                    req_valid = 1'b0;
                    break;
                end
            end
            @(negedge clk); #1;
        end
        req_valid = 1'b0;
        $display("back-to-back: t1=%0d l1=%h t2=%0d l2=%h", t1, l1, t2, l2);
        n_cmp++; if (t1 !== 65) begin n_fail++; $display("FAIL b2b_first_done got %0d want 65", t1); end
        n_cmp++; if (l1 !== 64'd6) begin n_fail++; $display("FAIL b2b_first_l got %h want 6", l1); end
        n_cmp++; if (t2 !== 131) begin n_fail++; $display("FAIL b2b_second_done got %0d want 131", t2); end
        n_cmp++; if (l2 !== 64'd20) begin n_fail++; $display("FAIL b2b_second_l got %h want 14", l2); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_word();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
